// File: rtl/fir8_pkg.sv
// -----------------------------------------------------------------------------
// fir8_pkg
// Shared types and constants for the 8-lane FIR stream controller.
//   DW         default sample width
//   LANES      lanes per block handed to the FFA FIR core
//   NW         width of a per-block real-sample count (1..8)
//   lane_vec_t one block of lanes, lane 0 in the low slice
//   state_t    input-side scheduler states
//   trk_t      per-issue tracking entry {valid, n, flushed}
//   sat_inc32  saturating 32-bit increment
// -----------------------------------------------------------------------------
package fir8_pkg;

    localparam int DW    = 16;
    localparam int LANES = 8;
    localparam int NW    = 4;

    typedef logic [DW-1:0]          lane_t;
    typedef lane_t [LANES-1:0]      lane_vec_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

    typedef struct packed {
        logic          valid;
        logic [NW-1:0] n;
        logic          flushed;
    } trk_t;

    // Counter step that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
    endfunction

endpackage

// File: rtl/fir8_out_serializer.sv
// -----------------------------------------------------------------------------
// fir8_out_serializer
// Result block buffer (OBUF blocks, circular) and valid/ready re-serialiser.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   cap, cap_n, cap_flushed capture strobe and block metadata from tracking
//   y_lanes                core result lanes, lane 0 in the low slice
//   m_data/m_valid/m_last  registered output stream
//   m_ready                downstream accept
//   blk_done               last real sample of a block handshaken this cycle
// A block leaves the buffer as soon as its final lane is loaded into the
// output register; the top-level occupancy counter only releases it at the
// handshake, so the buffer can never be written while full.
// -----------------------------------------------------------------------------
module fir8_out_serializer
    import fir8_pkg::*;
#(
    parameter int DW   = fir8_pkg::DW,
    parameter int OBUF = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cap,
    input  logic [NW-1:0]              cap_n,
    input  logic                       cap_flushed,
    input  logic [LANES-1:0][DW-1:0]   y_lanes,
    input  logic                       m_ready,
    output logic [DW-1:0]              m_data,
    output logic                       m_valid,
    output logic                       m_last,
    output logic                       blk_done
);

    localparam int PW = (OBUF > 1) ? $clog2(OBUF) : 1;
    localparam int CW = $clog2(OBUF + 1);

    logic [LANES-1:0][DW-1:0] buf_r [OBUF];
    logic [NW-1:0]            meta_n_r [OBUF];
    logic                     meta_fl_r [OBUF];
    logic [PW-1:0]            wr_ptr_r;
    logic [PW-1:0]            rd_ptr_r;
    logic [CW-1:0]            bcnt_r;
    logic [2:0]               idx_r;
    logic                     cur_end_r;
    logic [DW-1:0]            m_data_r;
    logic                     m_valid_r;
    logic                     m_last_r;

    logic                     at_end_s;
    logic                     ld_s;
    logic                     pop_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OBUF - 1)) ? {PW{1'b0}} : (p + {{(PW-1){1'b0}}, 1'b1});
    endfunction

    // Load/pop decisions for the next output sample.
    always_comb begin
        at_end_s = ({1'b0, idx_r} == (meta_n_r[rd_ptr_r] - 4'd1));
        ld_s     = (!m_valid_r || m_ready) && (bcnt_r != {CW{1'b0}});
        pop_s    = ld_s && at_end_s;
    end

    assign blk_done = m_valid_r && m_ready && cur_end_r;
    assign m_data   = m_data_r;
    assign m_valid  = m_valid_r;
    assign m_last   = m_last_r;

    // Capture side: write a returning block into the next free slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            for (int i = 0; i < OBUF; i++) begin
                buf_r[i]     <= '0;
                meta_n_r[i]  <= {NW{1'b0}};
                meta_fl_r[i] <= 1'b0;
            end
        end else if (cap) begin
            buf_r[wr_ptr_r]     <= y_lanes;
            meta_n_r[wr_ptr_r]  <= cap_n;
            meta_fl_r[wr_ptr_r] <= cap_flushed;
            wr_ptr_r            <= ptr_inc(wr_ptr_r);
        end
    end

    // Number of blocks resident in the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt_r <= {CW{1'b0}};
        end else begin
            bcnt_r <= bcnt_r + CW'(cap) - CW'(pop_s);
        end
    end

    // Output register and lane walk; holds while the sink stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r  <= {PW{1'b0}};
            idx_r     <= 3'd0;
            cur_end_r <= 1'b0;
            m_data_r  <= {DW{1'b0}};
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
        end else if (ld_s) begin
            m_data_r  <= buf_r[rd_ptr_r][idx_r];
            m_valid_r <= 1'b1;
            m_last_r  <= at_end_s && meta_fl_r[rd_ptr_r];
            cur_end_r <= at_end_s;
            if (at_end_s) begin
                idx_r    <= 3'd0;
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end else begin
                idx_r    <= idx_r + 3'd1;
            end
        end else if (m_ready) begin
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
            cur_end_r <= 1'b0;
        end
    end

endmodule

// File: rtl/fir8_stream_ctrl.sv
// -----------------------------------------------------------------------------
// fir8_stream_ctrl
// Stream scheduler for the 8-parallel FFA FIR core: packs serial samples into
// 8-lane blocks, strobes fir_en once per block, tracks core latency and
// re-serialises the returned blocks with valid/ready backpressure.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   s_data/s_valid/s_ready, flush  serial input stream, partial-block flush
//   m_data/m_valid/m_ready, m_last serial output stream
//   fir_en, x8k..x8k_7             block issue to the core
//   y8k..y8k_7                     core results (LAT cycles after fir_en)
//   busy                           partial, in-flight or buffered data exists
// Build option FIR8_CTRL_STATS_EN adds saturating counters blk_cnt, stall_cnt.
// -----------------------------------------------------------------------------
module fir8_stream_ctrl
    import fir8_pkg::*;
#(
    parameter int DW   = fir8_pkg::DW,
    parameter int LAT  = 2,
    parameter int OBUF = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic          flush,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_last,
    output logic          fir_en,
    output logic [DW-1:0] x8k,
    output logic [DW-1:0] x8k_1,
    output logic [DW-1:0] x8k_2,
    output logic [DW-1:0] x8k_3,
    output logic [DW-1:0] x8k_4,
    output logic [DW-1:0] x8k_5,
    output logic [DW-1:0] x8k_6,
    output logic [DW-1:0] x8k_7,
    input  logic [DW-1:0] y8k,
    input  logic [DW-1:0] y8k_1,
    input  logic [DW-1:0] y8k_2,
    input  logic [DW-1:0] y8k_3,
    input  logic [DW-1:0] y8k_4,
    input  logic [DW-1:0] y8k_5,
    input  logic [DW-1:0] y8k_6,
    input  logic [DW-1:0] y8k_7,
    output logic          busy
`ifdef FIR8_CTRL_STATS_EN
    ,
    output logic [31:0]   blk_cnt,
    output logic [31:0]   stall_cnt
`endif
);

    localparam int OCW = $clog2(OBUF + 1);

    state_t                   state_r;
    logic [2:0]               cnt_r;
    logic [LANES-1:0][DW-1:0] fill_r;
    logic [LANES-1:0][DW-1:0] x_r;
    logic [NW-1:0]            n_r;
    logic                     flushed_r;
    logic                     fir_en_r;
    logic                     busy_r;
    logic [OCW-1:0]           occ_r;
    trk_t                     trk_r [LAT];

    logic                     accept_s;
    logic                     to_issue_s;
    logic                     issue_go_s;
    state_t                   state_nxt_s;
    logic [2:0]               cnt_nxt_s;
    logic [OCW-1:0]           occ_nxt_s;
    logic [LANES-1:0][DW-1:0] x_nxt_s;
    logic                     blk_done_s;

    assign s_ready = (state_r == ST_FILL);

    // Next-state, lane counter and issue decisions.
    always_comb begin
        accept_s    = s_valid && (state_r == ST_FILL);
        // A flush that coincides with an accept always closes the block,
        // even from an empty block (n becomes cnt+1).
        to_issue_s  = (state_r == ST_FILL) &&
                      ((accept_s && (cnt_r == 3'd7)) ||
                       (flush && (accept_s || (cnt_r != 3'd0))));
        issue_go_s  = (state_r == ST_ISSUE) && (occ_r < OCW'(OBUF));
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE:  state_nxt_s = ST_FILL;
            ST_FILL:  state_nxt_s = to_issue_s ? ST_ISSUE : ST_FILL;
            ST_ISSUE: state_nxt_s = issue_go_s ? ST_FILL : ST_ISSUE;
            default:  state_nxt_s = ST_IDLE;
        endcase
        if (issue_go_s) begin
            cnt_nxt_s = 3'd0;
        end else if (accept_s) begin
            cnt_nxt_s = cnt_r + 3'd1;
        end else begin
            cnt_nxt_s = cnt_r;
        end
        occ_nxt_s = occ_r + OCW'(fir_en_r) - OCW'(blk_done_s);
    end

    // Issued lanes: real samples below n, zero padding above.
    always_comb begin
        x_nxt_s = '0;
        for (int i = 0; i < LANES; i++) begin
            if (i < int'(n_r)) begin
                x_nxt_s[i] = fill_r[i];
            end else begin
                x_nxt_s[i] = {DW{1'b0}};
            end
        end
    end

    // Scheduler FSM with registered fir_en, lanes and busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 3'd0;
            fill_r    <= '0;
            x_r       <= '0;
            n_r       <= {NW{1'b0}};
            flushed_r <= 1'b0;
            fir_en_r  <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            fir_en_r <= issue_go_s;
            busy_r   <= (cnt_nxt_s != 3'd0) || (state_nxt_s == ST_ISSUE) ||
                        (occ_nxt_s != {OCW{1'b0}});
            if (accept_s) begin
                fill_r[cnt_r] <= s_data;
            end
            if (to_issue_s) begin
                n_r       <= accept_s ? ({1'b0, cnt_r} + 4'd1) : {1'b0, cnt_r};
                flushed_r <= flush;
            end
            if (issue_go_s) begin
                x_r <= x_nxt_s;
            end
        end
    end

    // Blocks issued but not yet fully handshaken on the output side.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_r <= {OCW{1'b0}};
        end else begin
            occ_r <= occ_nxt_s;
        end
    end

    // Latency tracker: stage LAT-1 is valid in the cycle the core output is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LAT; k++) begin
                trk_r[k] <= '0;
            end
        end else begin
            trk_r[0] <= {fir_en_r, n_r, flushed_r};
            for (int k = 1; k < LAT; k++) begin
                trk_r[k] <= trk_r[k-1];
            end
        end
    end

    fir8_out_serializer #(
        .DW   (DW),
        .OBUF (OBUF)
    ) u_ser (
        .clk         (clk),
        .rst_n       (rst_n),
        .cap         (trk_r[LAT-1].valid),
        .cap_n       (trk_r[LAT-1].n),
        .cap_flushed (trk_r[LAT-1].flushed),
        .y_lanes     ({y8k_7, y8k_6, y8k_5, y8k_4, y8k_3, y8k_2, y8k_1, y8k}),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_last      (m_last),
        .blk_done    (blk_done_s)
    );

    assign fir_en = fir_en_r;
    assign busy   = busy_r;
    assign x8k    = x_r[0];
    assign x8k_1  = x_r[1];
    assign x8k_2  = x_r[2];
    assign x8k_3  = x_r[3];
    assign x8k_4  = x_r[4];
    assign x8k_5  = x_r[5];
    assign x8k_6  = x_r[6];
    assign x8k_7  = x_r[7];

`ifdef FIR8_CTRL_STATS_EN
    logic [31:0] blk_cnt_r;
    logic [31:0] stall_cnt_r;

    // Saturating issue and issue-wait counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt_r   <= 32'd0;
            stall_cnt_r <= 32'd0;
        end else begin
            if (fir_en_r) begin
                blk_cnt_r <= sat_inc32(blk_cnt_r);
            end
            if ((state_r == ST_ISSUE) && !issue_go_s) begin
                stall_cnt_r <= sat_inc32(stall_cnt_r);
            end
        end
    end

    assign blk_cnt   = blk_cnt_r;
    assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: doc/fir8_stream_ctrl.md
Name: fir8_stream_ctrl

Overview:
Stream scheduler for the 8-parallel FFA FIR core `fir`. It packs a serial 16-bit sample stream into 8-lane blocks and issues one block per `fir_en` pulse. It tracks the core pipeline latency and buffers the returned 8-lane results. It re-serialises those results onto a valid/ready output stream with backpressure-safe credit control.

Parameters:
DW, 16, sample width (input and output)
LAT, 2, clock cycles from a `fir_en` pulse to valid `y8k..y8k_7` at the core outputs
OBUF, 2, result block buffer depth (blocks); also the maximum number of blocks in flight plus buffered

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
s_data  input  DW  serial input sample, signed
s_valid  input  1  input sample valid
s_ready  output  1  controller accepts a sample this cycle
flush  input  1  single-cycle pulse: issue the partial block zero-padded
m_data  output  DW  serial output sample, signed
m_valid  output  1  output sample valid
m_ready  input  1  downstream accepts the output sample
m_last  output  1  last real sample of a flushed block
fir_en  output  1  advance strobe to the FIR core (delay line updates only when 1)
x8k..x8k_7  output  DW each  block lanes to the core; lane i = sample 8k+i, lane 0 arrives first
y8k..y8k_7  input  DW each  core results, same lane order
busy  output  1  partial block held, or any block in flight or buffered

Behaviour:
- Clock, reset, and FIR lanes:
  - One clock `clk`; reset `rst_n` is asynchronous, active-low.
  - All registered outputs reset to 0: `x` lanes, `fir_en`, `m_data`, `m_valid`, `m_last`, `busy`.
  - `s_ready` is 0 while `rst_n` is low.
- FSM states: IDLE, FILL, ISSUE.
  - IDLE: entered at reset; moves to FILL on the first clock after `rst_n` deasserts.
  - FILL: `s_ready`=1. On `s_valid`&`s_ready`, write `s_data` into lane `cnt` and increment `cnt` (3 bits).
    - On accepting lane 7, go to ISSUE with `n`=8.
    - `flush` with `cnt`>0 (and no accept in the same cycle) goes to ISSUE with `n`=`cnt`; lanes `cnt`..7 are zero-filled.
    - `flush` with `cnt`=0 is ignored.
    - `flush` in the same cycle as the lane-7 accept: the block issues normally and the flush is consumed.
    - `flush` in the same cycle as a lane <7 accept: the accepted sample is included, `n`=`cnt`+1.
  - ISSUE: `s_ready`=0.
    - If `occ` < OBUF: drive `fir_en`=1 for exactly one cycle, clear `cnt`, return to FILL.
    - Otherwise wait in ISSUE.
    - There is no same-cycle bypass when `occ` decrements.
- `x` lanes are registered and stable from the issuing cycle until the next issue. `fir_en`=0 at all other times.
- Sustained input throughput is 8 samples per 9 cycles.
- Tracking:
  - A LAT-deep shift register carries {valid, n, flushed} per `fir_en` pulse.
  - At exactly LAT cycles after `fir_en`, `y8k..y8k_7` are captured into the next free slot of the OBUF-block result buffer (circular, write/read pointers wrap modulo OBUF).
- `occ`:
  - Increments on `fir_en`.
  - Decrements on the handshake of the last real sample of a block.
  - Both in the same cycle: `occ` is unchanged.
  - `occ` never exceeds OBUF, so a capture never finds the buffer full.
- Output serialiser:
  - Emits lanes 0..`n`-1 of the oldest buffered block, one per `m_valid`&`m_ready`.
  - `m_data`/`m_valid`/`m_last` are held stable while `m_valid`&!`m_ready`.
  - Padded lanes are never emitted.
  - `m_last`=1 only on sample `n`-1 of a flushed block (including a flushed block with `n`=8 via the lane-7 case).
  - Back-to-back blocks stream with no bubble.
- Arithmetic: lanes pass through unmodified; the core's two's-complement truncation to DW is owned by the core.
- `busy` = (`cnt`≠0) | (state==ISSUE) | (`occ`≠0).
- Reset mid-operation: all state, `cnt`, `occ`, pointers and tracking clear immediately; partial and in-flight data is discarded.

Optional Feature:
FIR8_CTRL_STATS_EN
- Defined: adds outputs `blk_cnt`[31:0] and `stall_cnt`[31:0].
  - `blk_cnt` increments per `fir_en`.
  - `stall_cnt` increments per cycle spent in ISSUE with `fir_en`=0.
  - Both saturate at all-ones and reset to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Package `fir8_pkg`: DW and LANES=8 constants, lane vector typedef, FSM state enum, tracking-entry struct {valid, n[3:0], flushed}.
- One sub-module, `fir8_out_serializer`, holding the result buffer, read/write pointers, and the m-side handshake.

Test Plan:
Bench uses a stub core: `y` lane i = `x` lane i, delayed LAT cycles, latched on `fir_en`.
- Reset then 16 samples 1..16 with `s_valid` held and `m_ready`=1 -> two `fir_en` pulses 9 cycles apart; `m_data` 1..16 in order; `m_last` never asserts; `busy`=0 afterwards.
- Samples 1..3 then `flush` -> one `fir_en`, `x8k_3..x8k_7`=0; output 1,2,3 with `m_last` on 3.
- `flush` on the cycle lane 7 (sample 8) is accepted -> exactly one block; 8 outputs; `m_last` on sample 8.
- `m_ready`=0 for 40 cycles while streaming -> at most OBUF=2 `fir_en` pulses; third block waits in ISSUE with `s_ready`=0; no data lost or reordered after `m_ready`=1.
- Random `s_valid`/`m_ready` (50%), 1000 samples including -32768 and 32767 -> output stream equals input stream.
- `rst_n` low mid-block with `occ`=2 -> all outputs 0 asynchronously; after release the first output equals the first new sample.
